// File: rtl/numpad_tx_sched_if.sv
// Frame input, UART character handshake and drop strobe between numpad_tx_sched and its neighbours.
// slave: the scheduler view; master: the numpad/UART side that drives the scheduler inputs.
interface numpad_tx_sched_if;
  logic [3:0] i_tx_data1;
  logic [3:0] i_tx_data2;
  logic [3:0] i_tx_data3;
  logic [3:0] i_tx_data4;
  logic       i_tx_valid;
  logic       o_tx_busy;
  logic [7:0] o_uart_data;
  logic       o_uart_valid;
  logic       i_uart_busy;
  logic       o_drop;

  modport slave (
    input  i_tx_data1, i_tx_data2, i_tx_data3, i_tx_data4, i_tx_valid, i_uart_busy,
    output o_tx_busy, o_uart_data, o_uart_valid, o_drop
  );

  modport master (
    output i_tx_data1, i_tx_data2, i_tx_data3, i_tx_data4, i_tx_valid, i_uart_busy,
    input  o_tx_busy, o_uart_data, o_uart_valid, o_drop
  );
endinterface

// File: rtl/numpad_tx_sched.sv
// Converts 4-nibble numpad frames to ASCII hex and feeds them to the UART TX, one pending frame deep.
// Define NUMPAD_TX_CRLF_EN to append CR LF after the fourth digit.
module numpad_tx_sched #(
  parameter int unsigned ACK_TIMEOUT = 4,
  parameter bit          UPPERCASE   = 1'b1
) (
  input logic             clk,
  input logic             i_rst_n,
  numpad_tx_sched_if.slave bus
);

  localparam int unsigned NIB_W   = 4;
  localparam int unsigned FRAME_W = 4 * NIB_W;
  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned ACK_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
`ifdef NUMPAD_TX_CRLF_EN
  localparam int unsigned LAST = 5;
`else
  localparam int unsigned LAST = 3;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_ADVANCE
  } state_t;

  state_t               state, state_nxt;
  logic [FRAME_W-1:0]   active, active_nxt;
  logic [FRAME_W-1:0]   pending, pending_nxt;
  logic                 pending_full, pending_full_nxt;
  logic [IDX_W-1:0]     char_idx, char_idx_nxt;
  logic [ACK_W-1:0]     ack_cnt, ack_cnt_nxt;
  logic                 uart_valid, uart_valid_nxt;
  logic [CHAR_W-1:0]    uart_data, uart_data_nxt;
  logic                 drop, drop_nxt;
  logic                 accept;
  logic [FRAME_W-1:0]   frame_in;

  // Character at position idx of a frame packed as {d1, d2, d3, d4}.
  function automatic logic [CHAR_W-1:0] to_char(input logic [FRAME_W-1:0] frame,
                                                 input logic [IDX_W-1:0]   idx);
    logic [NIB_W-1:0]  nib;
    logic [CHAR_W-1:0] ch;
    nib = '0;
    case (idx)
      3'd0:    nib = frame[15:12];
      3'd1:    nib = frame[11:8];
      3'd2:    nib = frame[7:4];
      3'd3:    nib = frame[3:0];
      default: nib = '0;
    endcase
    if (nib < NIB_W'(10)) begin
      ch = 8'h30 + CHAR_W'(nib);
    end else begin
      ch = (UPPERCASE ? 8'h37 : 8'h57) + CHAR_W'(nib);
    end
`ifdef NUMPAD_TX_CRLF_EN
    if (idx == 3'd4) ch = 8'h0D;
    if (idx == 3'd5) ch = 8'h0A;
`endif
    return ch;
  endfunction

  assign frame_in = {bus.i_tx_data1, bus.i_tx_data2, bus.i_tx_data3, bus.i_tx_data4};
  // The busy flag seen by numpad is the registered pending flag, so acceptance uses it directly.
  assign accept   = bus.i_tx_valid && !pending_full;

  // Next-state, pending-slot and registered-output computation.
  always_comb begin
    state_nxt        = state;
    active_nxt       = active;
    pending_nxt      = pending;
    pending_full_nxt = pending_full;
    char_idx_nxt     = char_idx;
    ack_cnt_nxt      = ack_cnt;
    drop_nxt         = bus.i_tx_valid && pending_full;

    case (state)
      ST_IDLE: begin
        if (pending_full) begin
          active_nxt       = pending;
          pending_full_nxt = 1'b0;
          char_idx_nxt     = '0;
          state_nxt        = ST_ISSUE;
        end else if (accept) begin
          active_nxt   = frame_in;
          char_idx_nxt = '0;
          state_nxt    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!bus.i_uart_busy) begin
          ack_cnt_nxt = '0;
          state_nxt   = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (bus.i_uart_busy) begin
          state_nxt = ST_WAIT_DONE;
        end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
          state_nxt = ST_ADVANCE;
        end else begin
          ack_cnt_nxt = ack_cnt + ACK_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.i_uart_busy) state_nxt = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        if (char_idx < IDX_W'(LAST)) begin
          char_idx_nxt = char_idx + IDX_W'(1);
          state_nxt    = ST_ISSUE;
        end else if (pending_full) begin
          active_nxt       = pending;
          pending_full_nxt = 1'b0;
          char_idx_nxt     = '0;
          state_nxt        = ST_ISSUE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Any accepted frame outside IDLE parks in the pending slot; promotion requires it full, so no clash.
    if (accept && (state != ST_IDLE)) begin
      pending_nxt      = frame_in;
      pending_full_nxt = 1'b1;
    end

    uart_valid_nxt = (state_nxt == ST_ISSUE);
    uart_data_nxt  = (state_nxt == ST_ISSUE) ? to_char(active_nxt, char_idx_nxt) : uart_data;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      char_idx     <= '0;
      ack_cnt      <= '0;
      uart_valid   <= 1'b0;
      uart_data    <= 8'h00;
      drop         <= 1'b0;
    end else begin
      state        <= state_nxt;
      active       <= active_nxt;
      pending      <= pending_nxt;
      pending_full <= pending_full_nxt;
      char_idx     <= char_idx_nxt;
      ack_cnt      <= ack_cnt_nxt;
      uart_valid   <= uart_valid_nxt;
      uart_data    <= uart_data_nxt;
      drop         <= drop_nxt;
    end
  end

  assign bus.o_tx_busy    = pending_full;
  assign bus.o_uart_valid = uart_valid;
  assign bus.o_uart_data  = uart_data;
  assign bus.o_drop       = drop;

endmodule

// File: tb/tb_numpad_tx_sched.sv
// Directed bench for numpad_tx_sched: uppercase and lowercase instances run the same stimulus.
// A small UART model records every handoff with its cycle number.
module tb_numpad_tx_sched;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  int   mode;      // 0: busy 1 cycle after handoff for 10 cycles, 1: never busy, 2: busy driven by main
  int   hold;
  logic pend;

  logic [7:0] byte_q0[$];
  logic [7:0] byte_q1[$];
  int         hcyc[$];
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];

  numpad_tx_sched_if if0();
  numpad_tx_sched_if if1();

  assign if1.i_tx_data1  = if0.i_tx_data1;
  assign if1.i_tx_data2  = if0.i_tx_data2;
  assign if1.i_tx_data3  = if0.i_tx_data3;
  assign if1.i_tx_data4  = if0.i_tx_data4;
  assign if1.i_tx_valid  = if0.i_tx_valid;
  assign if1.i_uart_busy = if0.i_uart_busy;

  numpad_tx_sched #(.ACK_TIMEOUT(4), .UPPERCASE(1'b1)) dut_up (
    .clk(clk), .i_rst_n(rst_n), .bus(if0.slave)
  );
  numpad_tx_sched #(.ACK_TIMEOUT(4), .UPPERCASE(1'b0)) dut_lo (
    .clk(clk), .i_rst_n(rst_n), .bus(if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // UART model: samples the handshake on the edge, updates busy 1 time unit later.
  initial begin
    logic       h;
    logic [7:0] d0, d1;
    forever begin
      @(posedge clk);
      h  = if0.o_uart_valid && !if0.i_uart_busy && rst_n;
      d0 = if0.o_uart_data;
      d1 = if1.o_uart_data;
      cyc++;
      #1;
      if (h) begin
        byte_q0.push_back(d0);
        byte_q1.push_back(d1);
        hcyc.push_back(cyc);
      end
      if (mode == 0) begin
        if (hold > 0) begin
          hold--;
          if (hold == 0) if0.i_uart_busy = 1'b0;
        end else if (pend) begin
          if0.i_uart_busy = 1'b1;
          hold = 10;
          pend = 1'b0;
        end
        if (h) pend = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    @(negedge clk);
    if0.i_tx_data1 = a;
    if0.i_tx_data2 = b;
    if0.i_tx_data3 = c;
    if0.i_tx_data4 = d;
    if0.i_tx_valid = 1'b1;
    @(posedge clk);
    #1;
    if0.i_tx_valid = 1'b0;
  endtask

  task automatic expect4(input logic [7:0] u0, input logic [7:0] u1, input logic [7:0] u2,
                         input logic [7:0] u3, input logic [7:0] l0, input logic [7:0] l1,
                         input logic [7:0] l2, input logic [7:0] l3);
    exp0.push_back(u0); exp0.push_back(u1); exp0.push_back(u2); exp0.push_back(u3);
    exp1.push_back(l0); exp1.push_back(l1); exp1.push_back(l2); exp1.push_back(l3);
`ifdef NUMPAD_TX_CRLF_EN
    exp0.push_back(8'h0D); exp0.push_back(8'h0A);
    exp1.push_back(8'h0D); exp1.push_back(8'h0A);
`endif
  endtask

  task automatic clear_q();
    byte_q0.delete();
    byte_q1.delete();
    hcyc.delete();
    exp0.delete();
    exp1.delete();
  endtask

  // Bounded wait for all expected handoffs, then idle settling time.
  task automatic wait_bytes(input string tag, input int budget);
    int k;
    k = 0;
    while (byte_q0.size() < exp0.size() && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk({tag, "_in_time"}, 32'(k < budget), 32'd1);
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic cmp_bytes(input string tag, input int gap);
    logic [31:0] o0, o1;
    chk({tag, "_count"}, 32'(byte_q0.size()), 32'(exp0.size()));
    for (int i = 0; i < exp0.size(); i++) begin
      o0 = (i < byte_q0.size()) ? 32'(byte_q0[i]) : 32'bx;
      o1 = (i < byte_q1.size()) ? 32'(byte_q1[i]) : 32'bx;
      chk($sformatf("%s_up%0d", tag, i), o0, 32'(exp0[i]));
      chk($sformatf("%s_lo%0d", tag, i), o1, 32'(exp1[i]));
    end
    for (int i = 1; i < hcyc.size(); i++) begin
      chk($sformatf("%s_gap%0d", tag, i), 32'(hcyc[i] - hcyc[i-1]), 32'(gap));
    end
    chk({tag, "_idle_valid"}, 32'(if0.o_uart_valid), 32'd0);
    chk({tag, "_idle_busy"}, 32'(if0.o_tx_busy), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    mode  = 0;
    hold  = 0;
    pend  = 1'b0;
    rst_n = 1'b0;
    if0.i_tx_data1  = 4'h0;
    if0.i_tx_data2  = 4'h0;
    if0.i_tx_data3  = 4'h0;
    if0.i_tx_data4  = 4'h0;
    if0.i_tx_valid  = 1'b0;
    if0.i_uart_busy = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_busy", 32'(if0.o_tx_busy), 32'd0);
    chk("rst_uart_valid", 32'(if0.o_uart_valid), 32'd0);
    chk("rst_uart_data", 32'(if0.o_uart_data), 32'h00);
    chk("rst_drop", 32'(if0.o_drop), 32'd0);
    chk("rst_lo_valid", 32'(if1.o_uart_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 1,2,3,4 with a 10-cycle busy UART; valid one cycle after the strobe
    clear_q();
    expect4(8'h31, 8'h32, 8'h33, 8'h34, 8'h31, 8'h32, 8'h33, 8'h34);
    send_frame(4'h1, 4'h2, 4'h3, 4'h4);
    chk("f1_valid_lat", 32'(if0.o_uart_valid), 32'd1);
    chk("f1_data_lat", 32'(if0.o_uart_data), 32'h31);
    chk("f1_tx_busy", 32'(if0.o_tx_busy), 32'd0);
    wait_bytes("f1", 400);
    cmp_bytes("f1", 14);

    // Hex letters, both case settings
    clear_q();
    expect4(8'h41, 8'h42, 8'h43, 8'h46, 8'h61, 8'h62, 8'h63, 8'h66);
    send_frame(4'hA, 4'hB, 4'hC, 4'hF);
    wait_bytes("hex", 400);
    cmp_bytes("hex", 14);

    // Pending frame follows without a gap; third frame while busy is dropped
    clear_q();
    expect4(8'h31, 8'h32, 8'h33, 8'h34, 8'h31, 8'h32, 8'h33, 8'h34);
    expect4(8'h30, 8'h30, 8'h30, 8'h39, 8'h30, 8'h30, 8'h30, 8'h39);
    send_frame(4'h1, 4'h2, 4'h3, 4'h4);
    repeat (5) @(posedge clk);
    send_frame(4'h0, 4'h0, 4'h0, 4'h9);
    chk("pend_tx_busy", 32'(if0.o_tx_busy), 32'd1);
    chk("pend_no_drop", 32'(if0.o_drop), 32'd0);
    repeat (3) @(posedge clk);
    send_frame(4'hF, 4'hE, 4'hD, 4'hC);
    chk("drop_pulse", 32'(if0.o_drop), 32'd1);
    @(posedge clk);
    #1;
    chk("drop_single", 32'(if0.o_drop), 32'd0);
    chk("drop_still_busy", 32'(if0.o_tx_busy), 32'd1);
    wait_bytes("pend", 800);
    cmp_bytes("pend", 14);

    // Busy held during ISSUE, then a UART that never raises busy
    clear_q();
    expect4(8'h39, 8'h38, 8'h37, 8'h36, 8'h39, 8'h38, 8'h37, 8'h36);
    mode = 2;
    @(negedge clk);
    if0.i_uart_busy = 1'b1;
    send_frame(4'h9, 4'h8, 4'h7, 4'h6);
    chk("hold_valid0", 32'(if0.o_uart_valid), 32'd1);
    chk("hold_data0", 32'(if0.o_uart_data), 32'h39);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_valid%0d", i), 32'(if0.o_uart_valid), 32'd1);
      chk($sformatf("hold_data%0d", i), 32'(if0.o_uart_data), 32'h39);
    end
    chk("hold_no_handoff", 32'(byte_q0.size()), 32'd0);
    mode = 1;
    if0.i_uart_busy = 1'b0;
    wait_bytes("tmo", 400);
    cmp_bytes("tmo", 6);

    // Reset during character 2, then a clean frame
    clear_q();
    mode = 0;
    expect4(8'h31, 8'h32, 8'h33, 8'h34, 8'h31, 8'h32, 8'h33, 8'h34);
    send_frame(4'h1, 4'h2, 4'h3, 4'h4);
    begin
      int k;
      k = 0;
      while (byte_q0.size() < 2 && k < 200) begin
        @(posedge clk);
        k++;
      end
      chk("rst2_reach_char2", 32'(k < 200), 32'd1);
    end
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst2_uart_valid", 32'(if0.o_uart_valid), 32'd0);
    chk("rst2_uart_data", 32'(if0.o_uart_data), 32'h00);
    chk("rst2_tx_busy", 32'(if0.o_tx_busy), 32'd0);
    chk("rst2_drop", 32'(if0.o_drop), 32'd0);
    chk("rst2_lo_valid", 32'(if1.o_uart_valid), 32'd0);
    if0.i_uart_busy = 1'b0;
    hold = 0;
    pend = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    expect4(8'h35, 8'h36, 8'h37, 8'h38, 8'h35, 8'h36, 8'h37, 8'h38);
    send_frame(4'h5, 4'h6, 4'h7, 4'h8);
    chk("rst2_new_data", 32'(if0.o_uart_data), 32'h35);
    wait_bytes("rst2", 400);
    cmp_bytes("rst2", 14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/numpad_tx_sched.md
Name: numpad_tx_sched

Overview:
- Sequences the UART transmitter on behalf of the numpad block.
- Accepts a 4-digit frame (four 4-bit nibbles plus a valid strobe) from numpad and converts each nibble to ASCII hex.
- Issues the characters one at a time to the UART TX under its busy handshake.
- Drives numpad's i_tx_busy back-pressure input and holds one pending frame while the current frame is being sent.

Parameters:
- ACK_TIMEOUT, 4: cycles to wait in WAIT_ACK for i_uart_busy to rise before treating the character as sent.
- UPPERCASE, 1: 1 maps nibbles 10-15 to 'A'-'F' (0x41-0x46); 0 maps them to 'a'-'f' (0x61-0x66).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_tx_data1  in  4  digit 1, transmitted first.
- i_tx_data2  in  4  digit 2.
- i_tx_data3  in  4  digit 3.
- i_tx_data4  in  4  digit 4, transmitted last.
- i_tx_valid  in  1  one-cycle frame strobe from numpad o_tx_valid.
- o_tx_busy  out  1  to numpad i_tx_busy; 1 = pending slot full, frame will not be accepted.
- o_uart_data  out  8  ASCII character to the UART TX.
- o_uart_valid  out  1  character request to the UART TX.
- i_uart_busy  in  1  UART TX busy.
- o_drop  out  1  one-cycle pulse when a frame is dropped.

Behaviour:
- Reset (async assert, sync release): state=IDLE, char_idx=0, pending_full=0, o_tx_busy=0, o_uart_valid=0, o_uart_data=8'h00, o_drop=0. Reset mid-frame abandons the frame; no partial resume.
- Outputs are registered. o_tx_busy equals pending_full.
- Frame acceptance: i_tx_valid=1 and o_tx_busy=0 at an edge.
  - If state=IDLE, the frame loads the active register, char_idx=0, and state goes to ISSUE. o_uart_valid is high in the next cycle (1-cycle latency).
  - Otherwise the frame loads the pending register and pending_full=1.
- i_tx_valid=1 while o_tx_busy=1: frame discarded, o_drop=1 for one cycle, no other state change.
- Char map: 0-9 maps to 0x30+d; 10-15 maps per UPPERCASE.
- FSM:
  - IDLE: o_uart_valid=0; waits for an accepted frame.
  - ISSUE: o_uart_valid=1, o_uart_data=char[char_idx]. If i_uart_busy=0 at the edge, the character is handed off and state goes to WAIT_ACK with ack_cnt=0. Otherwise stay in ISSUE (data held stable).
  - WAIT_ACK: o_uart_valid=0. i_uart_busy=1 goes to WAIT_DONE. ack_cnt==ACK_TIMEOUT-1 with busy still 0 goes to ADVANCE (fast UART). Otherwise ack_cnt++.
  - WAIT_DONE: i_uart_busy=0 goes to ADVANCE.
  - ADVANCE (1 cycle):
    - If char_idx < LAST: char_idx++ and go to ISSUE.
    - Else if pending_full: pending copies to active, pending_full=0, char_idx=0, go to ISSUE.
    - Else go to IDLE.
- LAST=3, or 5 with CRLF_EN.
- Simultaneous events:
  - A frame arriving on the same edge that ADVANCE frees the pending slot sees o_tx_busy=1 (registered) and is dropped with o_drop.
  - A frame arriving on the edge that enters IDLE goes to pending and is promoted on the next cycle.
- ack_cnt is wide enough for ACK_TIMEOUT (clog2). Character data stays stable from ISSUE until the handoff edge.

Optional Feature:
- Macro: NUMPAD_TX_CRLF_EN.
- Defined: after digit 4 the block sends 0x0D then 0x0A using the same ISSUE/WAIT handshake; LAST=5 (6 characters per frame).
- Undefined: 4 characters per frame, no terminator; LAST=3.

Test Plan:
- Reset then frame 1,2,3,4 with the UART model asserting busy 1 cycle after a handoff and holding it 10 cycles -> bytes 0x31,0x32,0x33,0x34 in order (plus 0x0D,0x0A with the macro); o_uart_valid first high 1 cycle after the strobe; then IDLE.
- Frame A,b-nibble 0xA,0xB,0xC,0xF, UPPERCASE=1 -> 0x41,0x42,0x43,0x46; with UPPERCASE=0 -> 0x61,0x62,0x63,0x66.
- Second frame 0,0,0,9 mid-transmission -> o_tx_busy=1 until promotion; it follows the first frame with no IDLE gap. A third frame while busy -> o_drop single pulse, and the third frame is never sent.
- i_uart_busy held 1 while in ISSUE for 5 cycles -> o_uart_valid stays 1 with stable data, and no handoff until busy drops.
- UART never raises busy -> each character advances after ACK_TIMEOUT=4 cycles in WAIT_ACK; all 4 characters still emitted.
- i_rst_n pulled low during character 2 -> all outputs return to reset values immediately (async); after release, a new frame 5,6,7,8 sends 0x35..0x38 only.
